cdiv_seq: RTL and testbench

- Sequential complex divider in signed Q-format fixed point: computes p = a / b = a·conj(b) / |b|², with a = ar + j·ai and b = br + j·bi.
- Inverse-direction companion to the team's pipelined complex multiplier (cmult); uses the same number format (default Q8.8 in a 16-bit word).
- Sits in the equalizer/normalization path after the multiplier stage.
- Uses a valid/ready handshake on both sides, a fixed iterative latency, and a saturating output with status flags.

---
 rtl/cdiv_pkg.sv | 8 +
 rtl/cdiv_seq_udiv_iter.sv | 34 +++
 rtl/cdiv_seq.sv | 128 ++++++++++++
 tb/tb_cdiv_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cdiv_pkg.sv
// cdiv_pkg: shared types and constants for the sequential complex divider.
package cdiv_pkg;
    typedef enum logic [2:0] {IDLE, PROD, DIV, SAT, DONE} state_t;
    localparam int Q_DEF = 8;
    localparam int N_DEF = 16;
    localparam logic [N_DEF-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [N_DEF-1:0] SAT_MIN = 16'h8000;
endpackage

// File: rtl/cdiv_seq_udiv_iter.sv
// udiv_iter: radix-2 restoring unsigned divider, one quotient bit per step.
module udiv_iter #(
    parameter int DW = 40,
    parameter int VW = 33
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quo
);
    logic [VW-1:0] dv, rem;
    logic [VW:0]   t;
    logic          ge;
    // Remainder stays below the divisor, so the shifted trial value fits in VW+1 bits.
    assign t  = {rem, quo[DW-1]};
    assign ge = t >= {1'b0, dv};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv  <= '0;
            rem <= '0;
            quo <= '0;
        end else if (load) begin
            dv  <= divisor;
            rem <= '0;
            quo <= dividend;
        end else if (step) begin
            rem <= ge ? VW'(t - {1'b0, dv}) : t[VW-1:0];
            quo <= {quo[DW-2:0], ge};
        end
    end
endmodule

// File: rtl/cdiv_seq.sv
// cdiv_seq: iterative complex divider p = a*conj(b)/|b|^2 in signed Q fixed point,
// with valid/ready handshakes, saturation and divide-by-zero flag.
module cdiv_seq import cdiv_pkg::*; #(
    parameter int Q = Q_DEF,
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] ar,
    input  logic [N-1:0] ai,
    input  logic [N-1:0] br,
    input  logic [N-1:0] bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pr,
    output logic [N-1:0] pi,
    output logic         dz,
    output logic         ovf
);
    localparam int K  = 2*N+Q;
    localparam int CW = $clog2(K);
    localparam logic [N-1:0] PMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] NMIN = {1'b1, {(N-1){1'b0}}};

    state_t st;
    logic signed [N-1:0]   ar_q, ai_q, br_q, bi_q;
    logic signed [2*N:0]   xr, xi, yr, yi, nr, ni, ds;
    logic        [2*N:0]   d, mr, mi;
    logic        [K-1:0]   qr, qi;
    logic        [N:0]     sat_r, sat_i;
    logic        [CW-1:0]  cnt;
    logic                  sr, si;

    assign in_ready = st == IDLE;
    assign xr = (2*N+1)'(ar_q);
    assign xi = (2*N+1)'(ai_q);
    assign yr = (2*N+1)'(br_q);
    assign yi = (2*N+1)'(bi_q);
    assign nr = xr*yr + xi*yi;
    assign ni = xi*yr - xr*yi;
    assign ds = yr*yr + yi*yi;
    assign d  = ds;
    assign mr = nr[2*N] ? -nr : nr;
    assign mi = ni[2*N] ? -ni : ni;

    // Negative results may reach one LSB further than positive ones.
    function automatic logic [N:0] sat(input logic s, input logic [K-1:0] m);
        logic [K-1:0] lim;
        logic         o;
        lim = K'(PMAX) + K'(s);
        o   = m > lim;
        return {o, o ? (s ? NMIN : PMAX) : (s ? N'(-m) : m[N-1:0])};
    endfunction

    assign sat_r = sat(sr, qr);
    assign sat_i = sat(si, qi);

    udiv_iter #(.DW(K), .VW(2*N+1)) u_re (
        .clk(clk), .rst_n(rst_n), .load(st == PROD), .step(st == DIV),
        .dividend({mr[2*N-1:0], {Q{1'b0}}}), .divisor(d), .quo(qr)
    );
    udiv_iter #(.DW(K), .VW(2*N+1)) u_im (
        .clk(clk), .rst_n(rst_n), .load(st == PROD), .step(st == DIV),
        .dividend({mi[2*N-1:0], {Q{1'b0}}}), .divisor(d), .quo(qi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            ar_q      <= '0;
            ai_q      <= '0;
            br_q      <= '0;
            bi_q      <= '0;
            sr        <= 1'b0;
            si        <= 1'b0;
            cnt       <= '0;
            pr        <= '0;
            pi        <= '0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (st)
                IDLE: if (in_valid) begin
                    ar_q <= ar;
                    ai_q <= ai;
                    br_q <= br;
                    bi_q <= bi;
                    st   <= PROD;
                end
                PROD: begin
                    sr  <= nr[2*N];
                    si  <= ni[2*N];
                    cnt <= '0;
                    if (d == '0) begin
                        pr        <= ar_q[N-1] ? NMIN : PMAX;
                        pi        <= ai_q[N-1] ? NMIN : PMAX;
                        dz        <= 1'b1;
                        ovf       <= 1'b0;
                        out_valid <= 1'b1;
                        st        <= DONE;
                    end else begin
                        st <= DIV;
                    end
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(K-1)) st <= SAT;
                end
                SAT: begin
                    pr        <= sat_r[N-1:0];
                    pi        <= sat_i[N-1:0];
                    ovf       <= sat_r[N] | sat_i[N];
                    dz        <= 1'b0;
                    out_valid <= 1'b1;
                    st        <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    st        <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cdiv_seq.sv
// tb_cdiv_seq: scoreboard bench for cdiv_seq; expected results queued at issue, compared on output.
module tb_cdiv_seq;
    typedef struct packed {
        logic [15:0] pr;
        logic [15:0] pi;
        logic        dz;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] ar = '0, ai = '0, br = '0, bi = '0;
    logic        in_ready, out_valid, dz, ovf;
    logic [15:0] pr, pi;
    res_t        sb[$];
    int          checks = 0;
    int          failures = 0;

    cdiv_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .out_valid(out_valid), .out_ready(out_ready),
        .pr(pr), .pi(pi), .dz(dz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] satq(input longint n, input longint d, output logic o);
        longint m;
        m = ((n < 0 ? -n : n) << 8) / d;
        if (n < 0) begin
            o = m > 32768;
            return o ? 16'h8000 : 16'(-m);
        end
        o = m > 32767;
        return o ? 16'h7FFF : 16'(m);
    endfunction

    function automatic res_t model(input logic [15:0] a_r, a_i, b_r, b_i);
        res_t   e;
        longint xr, xi, yr, yi, d;
        logic   o1, o2;
        xr = longint'($signed(a_r));
        xi = longint'($signed(a_i));
        yr = longint'($signed(b_r));
        yi = longint'($signed(b_i));
        d  = yr*yr + yi*yi;
        if (d == 0) begin
            e.pr  = xr < 0 ? 16'h8000 : 16'h7FFF;
            e.pi  = xi < 0 ? 16'h8000 : 16'h7FFF;
            e.dz  = 1'b1;
            e.ovf = 1'b0;
        end else begin
            e.pr  = satq(xr*yr + xi*yi, d, o1);
            e.pi  = satq(xi*yr - xr*yi, d, o2);
            e.dz  = 1'b0;
            e.ovf = o1 | o2;
        end
        return e;
    endfunction

    task automatic op(input logic [15:0] a_r, a_i, b_r, b_i, input res_t e,
                      input int elat, input int hold, input bit junk);
        res_t x;
        int   lat;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        ar = a_r; ai = a_i; br = b_r; bi = b_i;
        in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
            if (junk && lat == 5) begin
                check("in_ready_busy", in_ready, 1'b0);
                ar = 16'h1234; ai = 16'h4321; br = 16'h0001; bi = 16'h0000;
                in_valid = 1'b1;
            end
            if (junk && lat == 9) in_valid = 1'b0;
        end
        check("latency", lat, elat);
        x = sb.pop_front();
        check("pr", pr, x.pr);
        check("pi", pi, x.pi);
        check("dz", dz, x.dz);
        check("ovf", ovf, x.ovf);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1'b1);
            check("hold_out", {pr, pi, dz, ovf}, {x.pr, x.pi, x.dz, x.ovf});
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("valid_drop", out_valid, 1'b0);
        check("ready_back", in_ready, 1'b1);
        check("keep_out", {pr, pi, dz, ovf}, {x.pr, x.pi, x.dz, x.ovf});
    endtask

    initial begin
        int seen;
        logic [15:0] r0, r1, r2, r3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_out", {pr, pi, dz, ovf}, 34'd0);
        @(negedge clk) rst_n = 1'b1;

        op(16'h0180, 16'h0000, 16'h0080, 16'h0000, '{16'h0300, 16'h0000, 1'b0, 1'b0}, 42, 0, 0);
        op(16'hFC80, 16'h0000, 16'hFE80, 16'h0000, '{16'h0255, 16'h0000, 1'b0, 1'b0}, 42, 0, 0);
        op(16'h0080, 16'h0000, 16'hFE80, 16'h0000, '{16'hFFAB, 16'h0000, 1'b0, 1'b0}, 42, 0, 1);
        op(16'h0100, 16'h0100, 16'h0000, 16'h0100, '{16'h0100, 16'hFF00, 1'b0, 1'b0}, 42, 10, 0);
        op(16'h6400, 16'h9C00, 16'h0040, 16'h0000, '{16'h7FFF, 16'h8000, 1'b0, 1'b1}, 42, 0, 0);
        op(16'hFF00, 16'h0100, 16'h0000, 16'h0000, '{16'h8000, 16'h7FFF, 1'b1, 1'b0}, 1, 0, 0);
        op(16'h0000, 16'h0000, 16'h0100, 16'h0100, '{16'h0000, 16'h0000, 1'b0, 1'b0}, 42, 0, 0);

        // abort a computation partway through the divide
        @(negedge clk);
        ar = 16'h0300; ai = 16'h0100; br = 16'h0100; bi = 16'h0000;
        in_valid = 1'b1;
        @(negedge clk) in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        #1 check("abort_ready", in_ready, 1'b1);
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_out", seen, 0);

        op(16'h0300, 16'h0100, 16'h0100, 16'h0000, '{16'h0300, 16'h0100, 1'b0, 1'b0}, 42, 0, 0);

        for (int n = 0; n < 8; n++) begin
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            r2 = (n % 2 == 0) ? 16'($urandom) : 16'($signed(9'($urandom)));
            r3 = (n % 2 == 0) ? 16'($urandom) : 16'($signed(9'($urandom)));
            op(r0, r1, r2, r3, model(r0, r1, r2, r3), (r2 == 0 && r3 == 0) ? 1 : 42, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
